// File: rtl/lc3b_types.sv
// Shared LC-3b data types and the L2 request scheduler state encoding.
// Types only: no latency, no flow control.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RECOVER
    } sched_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; count_o updates one cycle after inc_i, sticks at all-ones.
// No backpressure: every increment is accepted, excess increments past all-ones are dropped.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/l2_req_scheduler.sv
// Arbitrates I/D L1 misses onto one L2 port; winner's command appears one cycle after grant.
// L1 strobes are held until resp; L2 completion (l2_resp_in) is the only backpressure, then one RECOVER cycle.
module l2_req_scheduler
    import lc3b_types::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  lc3b_word               i_cache_address_in,
    input  lc3b_word               d_cache_address_in,
    input  lc3b_cacheline          i_cache_wdata_in,
    input  lc3b_cacheline          d_cache_wdata_in,
    input  logic                   i_cache_read_in,
    input  logic                   i_cache_write_in,
    input  logic                   d_cache_read_in,
    input  logic                   d_cache_write_in,
    input  lc3b_cacheline          l2_rdata_in,
    input  logic                   l2_resp_in,
    output lc3b_word               l2_address_out,
    output lc3b_cacheline          l2_wdata_out,
    output logic                   l2_read_out,
    output logic                   l2_write_out,
    output logic                   i_cache_resp_out,
    output logic                   d_cache_resp_out,
    output lc3b_cacheline          i_cache_rdata_out,
    output lc3b_cacheline          d_cache_rdata_out,
    output logic [COUNT_WIDTH-1:0] i_grant_count,
    output logic [COUNT_WIDTH-1:0] d_grant_count
);
    sched_state_t  state_q, state_d;
    logic          last_was_d_q, last_was_d_d;
    lc3b_word      addr_q, addr_d;
    lc3b_cacheline wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;

    logic i_pend, d_pend, win_is_d;
    logic i_resp, d_resp;

    assign i_pend = i_cache_read_in | i_cache_write_in;
    assign d_pend = d_cache_read_in | d_cache_write_in;

    always_comb begin
        state_d      = state_q;
        last_was_d_d = last_was_d_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        win_is_d     = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    // On a tie, the side that did not win last time goes next.
                    win_is_d     = d_pend && (!i_pend || !last_was_d_q);
                    last_was_d_d = win_is_d;
                    if (win_is_d) begin
                        state_d = SERVE_D;
                        addr_d  = d_cache_address_in;
                        wdata_d = d_cache_wdata_in;
                        wr_d    = d_cache_write_in;
                        rd_d    = d_cache_read_in & ~d_cache_write_in;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = i_cache_address_in;
                        wdata_d = i_cache_wdata_in;
                        wr_d    = i_cache_write_in;
                        rd_d    = i_cache_read_in & ~i_cache_write_in;
                    end
                end
            end
            SERVE_I: begin
                i_resp = l2_resp_in;
                if (l2_resp_in) begin
                    state_d = RECOVER;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            SERVE_D: begin
                d_resp = l2_resp_in;
                if (l2_resp_in) begin
                    state_d = RECOVER;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_was_d_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_was_d_q <= last_was_d_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
        end
    end

    // A completion arriving while reset is asserted belongs to an aborted transaction.
    assign i_cache_resp_out  = i_resp & reset_n;
    assign d_cache_resp_out  = d_resp & reset_n;
    assign i_cache_rdata_out = l2_rdata_in;
    assign d_cache_rdata_out = l2_rdata_in;
    assign l2_address_out    = addr_q;
    assign l2_wdata_out      = wdata_q;
    assign l2_read_out       = rd_q;
    assign l2_write_out      = wr_q;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_i_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (i_cache_resp_out),
        .count_o (i_grant_count)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_d_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (d_cache_resp_out),
        .count_o (d_grant_count)
    );
endmodule
